cache_controller: RTL and testbench
===================================

Name: cache_controller

Overview:
FSM controller for a 4-way set-associative, write-back, write-allocate cache with LRU ageing, placed between CPU and main memory. Tag/data storage is external. The controller reads all four ways of the indexed set as candidate_1..4, compares tags, and writes back a single way via candidate_write and bank_selector. Memory transfers are whole 512-bit blocks.

Parameters:
WORD_SIZE 32 — CPU address/data width
BLOCK_OFFSET 4 — word-offset bits (16 words per block)
SETS 128 — number of sets
SETS_BITS 7 — index bits
AGE_BITS 2 — LRU age field width
TAG_BITS 21 — tag width (WORD_SIZE-SETS_BITS-BLOCK_OFFSET)
BLOCK_DATA_WIDTH 512 — block data width
DIRTY_BIT 1 / VALID_BIT 1 — flag widths
BANK 4 — associativity; bank_selector width

Ports:
clk in 1 — single clock, rising edge
rst_n in 1 — synchronous, active-high reset (asserted when 1)
cpu_req_addr in 32 — {tag[31:11], index[10:4], word[3:0]}
cpu_req_datain in 32 — write data
cpu_req_rw in 1 — 1=write, 0=read
cpu_req_enable in 1 — request strobe (one cycle is sufficient)
cpu_res_dataout out 32 — read data
cpu_res_ready out 1 — one-cycle completion pulse
mem_req_addr out 32 — block address {tag,index,4'b0}
mem_req_dataout out 512 — write-back block
mem_req_datain in 512 — fill block
mem_req_rw out 1 — 1=write-back, 0=fetch
mem_req_enable out 1 — memory request, held until mem_req_ready
mem_req_ready in 1 — memory done; fetch data is valid in the same cycle
cache_enable out 1 — storage access request
cache_rw out 1 — 0=read set, 1=write way
cache_ready in 1 — storage access done
candidate_1..4 in 537 each — way entry {valid[536], dirty[535], age[534:533], tag[532:512], data[511:0]}
age_1..age_4 out 2 each — updated LRU ages for ways 1..4, valid during a cache write
candidate_write out 537 — entry to store
bank_selector out 4 — one-hot way select for the write (bit0=way1)

Behaviour:
- Reset: state IDLE; all outputs 0; latched request cleared. Reset in any state aborts the operation without a response.
- IDLE: on cpu_req_enable, latch addr, data and rw, then go to READ_SET. cpu_req_enable is ignored in all other states.
- READ_SET: cache_enable=1, cache_rw=0. When cache_ready=1, register candidates 1..4 and go to COMPARE.
- COMPARE (1 cycle): hit = valid && tag match, lowest-numbered way wins on multiple matches.
  - Hit → UPDATE.
  - Miss: victim = lowest-numbered invalid way, else the way with the highest age (lowest index on ties). Dirty and valid victim → WRITE_BACK; otherwise → ALLOCATE.
- WRITE_BACK: mem_req_enable=1, rw=1, addr={victim tag, index, 4'b0}, dataout=victim data. On mem_req_ready → ALLOCATE.
- ALLOCATE: mem_req_enable=1, rw=0, addr={req tag, index, 4'b0}. On mem_req_ready, capture mem_req_datain as the block → UPDATE with target=victim.
- UPDATE: cache_enable=1, cache_rw=1, bank_selector=one-hot target.
  - candidate_write = {1, dirty, 2'b00, req tag, block}.
  - For a write, the word at data[word*32+:32] is replaced by cpu_req_datain and dirty=1. For a read, dirty keeps the old value on a hit and is 0 on a fill.
  - Ages: target way=0; every other valid way whose age < target's old age increments; others unchanged. An invalid target's old age is treated as 3.
  - When cache_ready=1 → RESPOND.
- RESPOND: cpu_res_ready=1 for one cycle. For reads, cpu_res_dataout = selected word; it holds until the next response. Next state IDLE.
- Outputs are registered or Moore-decoded from state. mem_req_enable and cache_enable drop in the cycle after their ready input.
- Minimum read-hit latency: request + READ_SET (storage latency) + COMPARE + UPDATE (storage latency) + RESPOND.

Test Plan:
- Read hit: addr 0x0001_5AC3 (tag 0x2B, index 0x2C, word 3); way1 valid, tag 0x2B, word i = 0xDEADBEEF+i → no memory request; bank_selector=0001; cpu_res_dataout=0xDEADBEF2; age_1=0.
- Clean read miss: no tag match, way1 invalid → one fetch with mem_req_rw=0, addr 0x0001_5AC0; line written to way1 (valid=1, dirty=0); data returned from mem_req_datain word 3.
- Dirty-eviction miss: all ways valid and dirty, ages 3,2,1,0, way1 tag 0x10 → write-back addr {0x10,0x2C,0}=0x0000_82C0 with way1 data, then fetch; ages out 0,3,2,1.
- Write hit in way3: write 0xCAFEBABE to word 3 → candidate_write word3=0xCAFEBABE, dirty=1, bank_selector=0100; no memory traffic; cpu_res_ready pulse.
- Write miss to a clean victim → fetch, then merged write with dirty=1; a following read to the same address returns 0xCAFEBABE as a hit.
- Reset asserted mid-ALLOCATE → next cycle IDLE, all outputs 0, no cpu_res_ready.

Source files
------------

// File: rtl/cache_controller.sv
// cache_controller: FSM for a 4-way set-associative, write-back, write-allocate
// cache with LRU ageing. Tag/data storage and main memory are external.
module cache_controller #(
  parameter int WORD_SIZE        = 32,
  parameter int BLOCK_OFFSET     = 4,
  parameter int SETS             = 128,
  parameter int SETS_BITS        = 7,
  parameter int AGE_BITS         = 2,
  parameter int TAG_BITS         = 21,
  parameter int BLOCK_DATA_WIDTH = 512,
  parameter int DIRTY_BIT        = 1,
  parameter int VALID_BIT        = 1,
  parameter int BANK             = 4,
  localparam int ENTRY_W = VALID_BIT + DIRTY_BIT + AGE_BITS + TAG_BITS + BLOCK_DATA_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [WORD_SIZE-1:0]        cpu_req_addr,
  input  logic [WORD_SIZE-1:0]        cpu_req_datain,
  input  logic                        cpu_req_rw,
  input  logic                        cpu_req_enable,
  output logic [WORD_SIZE-1:0]        cpu_res_dataout,
  output logic                        cpu_res_ready,
  output logic [WORD_SIZE-1:0]        mem_req_addr,
  output logic [BLOCK_DATA_WIDTH-1:0] mem_req_dataout,
  input  logic [BLOCK_DATA_WIDTH-1:0] mem_req_datain,
  output logic                        mem_req_rw,
  output logic                        mem_req_enable,
  input  logic                        mem_req_ready,
  output logic                        cache_enable,
  output logic                        cache_rw,
  input  logic                        cache_ready,
  input  logic [ENTRY_W-1:0]          candidate_1,
  input  logic [ENTRY_W-1:0]          candidate_2,
  input  logic [ENTRY_W-1:0]          candidate_3,
  input  logic [ENTRY_W-1:0]          candidate_4,
  output logic [AGE_BITS-1:0]         age_1,
  output logic [AGE_BITS-1:0]         age_2,
  output logic [AGE_BITS-1:0]         age_3,
  output logic [AGE_BITS-1:0]         age_4,
  output logic [ENTRY_W-1:0]          candidate_write,
  output logic [BANK-1:0]             bank_selector
);

  localparam int TAG_LSB   = BLOCK_DATA_WIDTH;
  localparam int AGE_LSB   = TAG_LSB + TAG_BITS;
  localparam int DIRTY_POS = AGE_LSB + AGE_BITS;
  localparam int VALID_POS = DIRTY_POS + DIRTY_BIT;
  localparam int WAY_W     = (BANK > 1) ? $clog2(BANK) : 1;

  if (SETS != (1 << SETS_BITS)) begin : g_bad_sets
    $error("cache_controller: SETS must equal 2**SETS_BITS");
  end

  typedef enum logic [2:0] {
    IDLE, READ_SET, COMPARE, WRITE_BACK, ALLOCATE, UPDATE, RESPOND
  } state_t;

  state_t                        state_q, state_d;
  logic [WORD_SIZE-1:0]          req_addr_q, req_data_q, rdata_q;
  logic                          req_rw_q;
  logic [ENTRY_W-1:0]            cand_q [BANK];
  logic [WAY_W-1:0]              target_q;
  logic [BLOCK_DATA_WIDTH-1:0]   block_q;
  logic                          keep_dirty_q;

  logic [TAG_BITS-1:0]           req_tag;
  logic [SETS_BITS-1:0]          req_idx;
  logic [BLOCK_OFFSET-1:0]       req_word;
  logic                          hit, inv_found;
  logic [WAY_W-1:0]              hit_way, inv_way, old_way, victim;
  logic [AGE_BITS-1:0]           old_age, tgt_age;
  logic [AGE_BITS-1:0]           age_new [BANK];
  logic [ENTRY_W-1:0]            new_entry;

  // Replace one word of a block with the CPU write data
  function automatic logic [BLOCK_DATA_WIDTH-1:0] put_word(
    input logic [BLOCK_DATA_WIDTH-1:0] blk,
    input logic [BLOCK_OFFSET-1:0]     word,
    input logic [WORD_SIZE-1:0]        data
  );
    logic [BLOCK_DATA_WIDTH-1:0] r;
    r = blk;
    r[word*WORD_SIZE +: WORD_SIZE] = data;
    return r;
  endfunction

  // Age of a non-target way: valid ways younger than the target grow one older
  function automatic logic [AGE_BITS-1:0] next_age(
    input logic                valid,
    input logic [AGE_BITS-1:0] age,
    input logic [AGE_BITS-1:0] target_age
  );
    return (valid && age < target_age) ? age + 1'b1 : age;
  endfunction

  assign req_tag  = req_addr_q[WORD_SIZE-1 -: TAG_BITS];
  assign req_idx  = req_addr_q[BLOCK_OFFSET +: SETS_BITS];
  assign req_word = req_addr_q[BLOCK_OFFSET-1:0];
  assign cpu_res_dataout = rdata_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst_n) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Request latch and the held read response
  always_ff @(posedge clk) begin
    if (rst_n) begin
      req_addr_q <= '0;
      req_data_q <= '0;
      req_rw_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      if (state_q == IDLE && cpu_req_enable) begin
        req_addr_q <= cpu_req_addr;
        req_data_q <= cpu_req_datain;
        req_rw_q   <= cpu_req_rw;
      end
      if (state_q == UPDATE && cache_ready && !req_rw_q)
        rdata_q <= block_q[req_word*WORD_SIZE +: WORD_SIZE];
    end
  end

  // Capture the set, the chosen way and the block that will be stored
  always_ff @(posedge clk) begin
    if (state_q == READ_SET && cache_ready) begin
      cand_q[0] <= candidate_1;
      cand_q[1] <= candidate_2;
      cand_q[2] <= candidate_3;
      cand_q[3] <= candidate_4;
    end
    if (state_q == COMPARE) begin
      target_q     <= hit ? hit_way : victim;
      block_q      <= cand_q[hit_way][BLOCK_DATA_WIDTH-1:0];
      keep_dirty_q <= hit & cand_q[hit_way][DIRTY_POS];
    end
    if (state_q == ALLOCATE && mem_req_ready)
      block_q <= mem_req_datain;
  end

  // Tag match (lowest way wins) and victim choice (first invalid, else oldest)
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    old_way   = '0;
    old_age   = '0;
    for (int i = BANK-1; i >= 0; i--) begin
      if (cand_q[i][VALID_POS] && cand_q[i][TAG_LSB +: TAG_BITS] == req_tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(i);
      end
      if (!cand_q[i][VALID_POS]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(i);
      end
    end
    for (int i = 0; i < BANK; i++) begin
      if (i == 0 || cand_q[i][AGE_LSB +: AGE_BITS] > old_age) begin
        old_age = cand_q[i][AGE_LSB +: AGE_BITS];
        old_way = WAY_W'(i);
      end
    end
    victim = inv_found ? inv_way : old_way;
  end

  // LRU ages and the merged entry written back into the target way
  always_comb begin
    tgt_age = cand_q[target_q][VALID_POS] ? cand_q[target_q][AGE_LSB +: AGE_BITS] : '1;
    for (int i = 0; i < BANK; i++) begin
      if (WAY_W'(i) == target_q) age_new[i] = '0;
      else age_new[i] = next_age(cand_q[i][VALID_POS], cand_q[i][AGE_LSB +: AGE_BITS], tgt_age);
    end
    new_entry = {1'b1, req_rw_q | keep_dirty_q, {AGE_BITS{1'b0}}, req_tag,
                 req_rw_q ? put_word(block_q, req_word, req_data_q) : block_q};
  end

  // Next state and Moore-decoded outputs
  always_comb begin
    state_d         = state_q;
    cache_enable    = 1'b0;
    cache_rw        = 1'b0;
    mem_req_enable  = 1'b0;
    mem_req_rw      = 1'b0;
    mem_req_addr    = '0;
    mem_req_dataout = '0;
    candidate_write = '0;
    bank_selector   = '0;
    cpu_res_ready   = 1'b0;
    age_1           = '0;
    age_2           = '0;
    age_3           = '0;
    age_4           = '0;
    unique case (state_q)
      IDLE: if (cpu_req_enable) state_d = READ_SET;
      READ_SET: begin
        cache_enable = 1'b1;
        if (cache_ready) state_d = COMPARE;
      end
      COMPARE: begin
        if (hit) state_d = UPDATE;
        else if (cand_q[victim][VALID_POS] && cand_q[victim][DIRTY_POS]) state_d = WRITE_BACK;
        else state_d = ALLOCATE;
      end
      WRITE_BACK: begin
        mem_req_enable  = 1'b1;
        mem_req_rw      = 1'b1;
        mem_req_addr    = {cand_q[target_q][TAG_LSB +: TAG_BITS], req_idx, {BLOCK_OFFSET{1'b0}}};
        mem_req_dataout = cand_q[target_q][BLOCK_DATA_WIDTH-1:0];
        if (mem_req_ready) state_d = ALLOCATE;
      end
      ALLOCATE: begin
        mem_req_enable = 1'b1;
        mem_req_addr   = {req_tag, req_idx, {BLOCK_OFFSET{1'b0}}};
        if (mem_req_ready) state_d = UPDATE;
      end
      UPDATE: begin
        cache_enable            = 1'b1;
        cache_rw                = 1'b1;
        bank_selector[target_q] = 1'b1;
        candidate_write         = new_entry;
        age_1                   = age_new[0];
        age_2                   = age_new[1];
        age_3                   = age_new[2];
        age_4                   = age_new[3];
        if (cache_ready) state_d = RESPOND;
      end
      RESPOND: begin
        cpu_res_ready = 1'b1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_controller.sv
// tb_cache_controller: directed scenarios plus randomized traffic against a
// flat word-memory reference (a cache must be transparent to the CPU).
module tb_cache_controller;

  logic         clk, rst_n;
  logic [31:0]  cpu_req_addr, cpu_req_datain, cpu_res_dataout, mem_req_addr;
  logic         cpu_req_rw, cpu_req_enable, cpu_res_ready;
  logic [511:0] mem_req_dataout, mem_req_datain;
  logic         mem_req_rw, mem_req_enable, mem_req_ready;
  logic         cache_enable, cache_rw, cache_ready;
  logic [536:0] candidate_1, candidate_2, candidate_3, candidate_4, candidate_write;
  logic [1:0]   age_1, age_2, age_3, age_4;
  logic [3:0]   bank_selector;

  cache_controller dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req_addr(cpu_req_addr), .cpu_req_datain(cpu_req_datain),
    .cpu_req_rw(cpu_req_rw), .cpu_req_enable(cpu_req_enable),
    .cpu_res_dataout(cpu_res_dataout), .cpu_res_ready(cpu_res_ready),
    .mem_req_addr(mem_req_addr), .mem_req_dataout(mem_req_dataout),
    .mem_req_datain(mem_req_datain), .mem_req_rw(mem_req_rw),
    .mem_req_enable(mem_req_enable), .mem_req_ready(mem_req_ready),
    .cache_enable(cache_enable), .cache_rw(cache_rw), .cache_ready(cache_ready),
    .candidate_1(candidate_1), .candidate_2(candidate_2),
    .candidate_3(candidate_3), .candidate_4(candidate_4),
    .age_1(age_1), .age_2(age_2), .age_3(age_3), .age_4(age_4),
    .candidate_write(candidate_write), .bank_selector(bank_selector)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // external storage, main memory and the CPU-visible reference
  logic [536:0] store [128][4];
  logic [6:0]   cur_idx = '0;
  logic [511:0] mem_blk [logic [27:0]];
  logic [31:0]  exp_words [logic [31:0]];
  bit           mem_hold = 1'b0;
  int           cwait = 0, mwait = 0;
  int           n_fetch = 0, n_wb = 0, wb_at_fetch = 0;
  logic [31:0]  last_fetch_addr = '0, last_wb_addr = '0;
  logic [511:0] last_wb_data = '0;
  logic [536:0] last_cw = '0;
  logic [3:0]   last_bank = '0;
  logic [7:0]   last_ages = '0;
  int           n_vec = 0, n_bad = 0;

  assign candidate_1 = store[cur_idx][0];
  assign candidate_2 = store[cur_idx][1];
  assign candidate_3 = store[cur_idx][2];
  assign candidate_4 = store[cur_idx][3];

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] get_blk(input logic [27:0] key);
    logic [511:0] r;
    if (mem_blk.exists(key)) return mem_blk[key];
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = 32'hA500_0000 ^ {key[23:0], 8'(i)};
    return r;
  endfunction

  function automatic logic [31:0] exp_read(input logic [31:0] a);
    logic [511:0] b;
    if (exp_words.exists(a)) return exp_words[a];
    b = get_blk(a[31:4]);
    return b[a[3:0]*32 +: 32];
  endfunction

  function automatic logic [511:0] pat_blk(input logic [31:0] base);
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = base + 32'(i);
    return r;
  endfunction

  function automatic logic [536:0] mk_entry(input logic v, input logic d, input logic [1:0] age,
                                            input logic [20:0] tag, input logic [511:0] data);
    return {v, d, age, tag, data};
  endfunction

  // storage and memory responders: random latency, act at the falling edge
  always @(negedge clk) begin
    logic [7:0] ag;
    if (rst_n) begin
      cache_ready = 1'b0; mem_req_ready = 1'b0; cwait = 0; mwait = 0;
    end else begin
      cache_ready = 1'b0;
      if (cache_enable) begin
        if (cwait == 0) begin
          cache_ready = 1'b1;
          cwait = $urandom_range(0, 2);
          if (cache_rw) begin
            ag = {age_4, age_3, age_2, age_1};
            for (int w = 0; w < 4; w++) begin
              if (bank_selector[w]) store[cur_idx][w] = candidate_write;
              else store[cur_idx][w][534:533] = ag[w*2 +: 2];
            end
            last_cw = candidate_write; last_bank = bank_selector; last_ages = ag;
          end
        end else cwait--;
      end
      mem_req_ready = 1'b0;
      if (mem_req_enable && !mem_hold) begin
        if (mwait == 0) begin
          mem_req_ready = 1'b1;
          mwait = $urandom_range(0, 3);
          if (mem_req_rw) begin
            mem_blk[mem_req_addr[31:4]] = mem_req_dataout;
            n_wb++; last_wb_addr = mem_req_addr; last_wb_data = mem_req_dataout;
          end else begin
            mem_req_datain = get_blk(mem_req_addr[31:4]);
            n_fetch++; last_fetch_addr = mem_req_addr; wb_at_fetch = n_wb;
          end
        end else mwait--;
      end
    end
  end

  task automatic do_req(input logic [31:0] a, input logic rw, input logic [31:0] d,
                        output logic [31:0] rd);
    bit done;
    @(posedge clk); #1;
    cur_idx = a[10:4];
    cpu_req_addr = a; cpu_req_datain = d; cpu_req_rw = rw; cpu_req_enable = 1'b1;
    @(posedge clk); #1;
    cpu_req_enable = 1'b0; cpu_req_addr = $urandom; cpu_req_datain = $urandom;
    cpu_req_rw = ~rw;
    done = 1'b0; rd = '0;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk);
      if (cpu_res_ready) begin done = 1'b1; rd = cpu_res_dataout; end
    end
    check("resp_seen", done, 1'b1);
    @(negedge clk);
    check("ready_pulse", cpu_res_ready, 1'b0);
  endtask

  task automatic check_quiet(input string p);
    check({p, "_cpu_ready"}, cpu_res_ready, 1'b0);
    check({p, "_mem_en"}, mem_req_enable, 1'b0);
    check({p, "_cache_en"}, cache_enable, 1'b0);
    check({p, "_bank"}, bank_selector, 4'b0);
    check({p, "_mem_addr"}, mem_req_addr, 32'h0);
    check({p, "_cw"}, candidate_write, 537'h0);
    check({p, "_rdata"}, cpu_res_dataout, 32'h0);
  endtask

  task automatic clear_set(input logic [6:0] s);
    for (int w = 0; w < 4; w++) store[s][w] = '0;
  endtask

  localparam logic [31:0] A = 32'h0001_5AC3;
  localparam logic [6:0]  IX = 7'h2C;

  initial begin
    logic [31:0]  rd;
    logic [511:0] blk, ref_blk;
    int           f0, w0, seen;
    bit           present, hit_after;
    logic [31:0]  ra, rdat;
    logic         rrw;

    for (int s = 0; s < 128; s++) clear_set(7'(s));
    rst_n = 1'b1; cpu_req_enable = 1'b0; cpu_req_addr = '0; cpu_req_datain = '0;
    cpu_req_rw = 1'b0; mem_req_datain = '0;
    repeat (3) @(negedge clk);
    check_quiet("reset");
    rst_n = 1'b0;

    // read hit in way1
    blk = pat_blk(32'hDEADBEEF);
    store[IX][0] = mk_entry(1, 0, 2, 21'h2B, blk);
    store[IX][1] = mk_entry(1, 0, 3, 21'h30, pat_blk(32'h1000));
    store[IX][2] = mk_entry(1, 0, 1, 21'h31, pat_blk(32'h2000));
    store[IX][3] = mk_entry(1, 0, 0, 21'h32, pat_blk(32'h3000));
    f0 = n_fetch; w0 = n_wb;
    do_req(A, 1'b0, 32'h0, rd);
    check("hit_rdata", rd, 32'hDEADBEF2);
    check("hit_no_fetch", n_fetch - f0, 0);
    check("hit_no_wb", n_wb - w0, 0);
    check("hit_bank", last_bank, 4'b0001);
    check("hit_ages", last_ages, {2'd1, 2'd2, 2'd3, 2'd0});
    check("hit_cw", last_cw, mk_entry(1, 0, 0, 21'h2B, blk));

    // clean read miss, way1 invalid
    clear_set(IX);
    f0 = n_fetch; w0 = n_wb;
    do_req(A, 1'b0, 32'h0, rd);
    ref_blk = get_blk(A[31:4]);
    check("miss_fetches", n_fetch - f0, 1);
    check("miss_no_wb", n_wb - w0, 0);
    check("miss_addr", last_fetch_addr, 32'h0001_5AC0);
    check("miss_bank", last_bank, 4'b0001);
    check("miss_cw", last_cw, mk_entry(1, 0, 0, 21'h2B, ref_blk));
    check("miss_ages", last_ages, 8'h00);
    check("miss_rdata", rd, ref_blk[3*32 +: 32]);

    // dirty eviction: all ways dirty, ages 3,2,1,0
    for (int w = 0; w < 4; w++)
      store[IX][w] = mk_entry(1, 1, 2'(3 - w), 21'(32'h10 + w), pat_blk(32'h7700_0000 + 32'(w << 8)));
    f0 = n_fetch; w0 = n_wb;
    do_req(A, 1'b0, 32'h0, rd);
    check("evict_wb_count", n_wb - w0, 1);
    check("evict_wb_addr", last_wb_addr, 32'h0000_82C0);
    check("evict_wb_data", last_wb_data, pat_blk(32'h7700_0000));
    check("evict_fetch_count", n_fetch - f0, 1);
    check("evict_wb_first", wb_at_fetch, w0 + 1);
    check("evict_fetch_addr", last_fetch_addr, 32'h0001_5AC0);
    check("evict_ages", last_ages, {2'd1, 2'd2, 2'd3, 2'd0});
    check("evict_bank", last_bank, 4'b0001);
    check("evict_rdata", rd, ref_blk[3*32 +: 32]);

    // write hit in way3
    blk = pat_blk(32'h5550_0000);
    store[IX][0] = mk_entry(1, 0, 0, 21'h40, pat_blk(32'h1));
    store[IX][1] = mk_entry(1, 0, 2, 21'h41, pat_blk(32'h2));
    store[IX][2] = mk_entry(1, 0, 1, 21'h2B, blk);
    store[IX][3] = '0;
    f0 = n_fetch; w0 = n_wb;
    do_req(A, 1'b1, 32'hCAFEBABE, rd);
    ref_blk = blk; ref_blk[3*32 +: 32] = 32'hCAFEBABE;
    check("wr_hit_bank", last_bank, 4'b0100);
    check("wr_hit_cw", last_cw, mk_entry(1, 1, 0, 21'h2B, ref_blk));
    check("wr_hit_mem", (n_fetch - f0) + (n_wb - w0), 0);
    check("wr_hit_ages", last_ages, {2'd0, 2'd0, 2'd2, 2'd1});

    // write miss to a clean victim, then read back as a hit
    clear_set(IX);
    f0 = n_fetch; w0 = n_wb;
    do_req(A, 1'b1, 32'hCAFEBABE, rd);
    ref_blk = get_blk(A[31:4]); ref_blk[3*32 +: 32] = 32'hCAFEBABE;
    check("wr_miss_fetch", n_fetch - f0, 1);
    check("wr_miss_no_wb", n_wb - w0, 0);
    check("wr_miss_cw", last_cw, mk_entry(1, 1, 0, 21'h2B, ref_blk));
    f0 = n_fetch;
    do_req(A, 1'b0, 32'h0, rd);
    check("rd_after_wr_data", rd, 32'hCAFEBABE);
    check("rd_after_wr_fetch", n_fetch - f0, 0);
    check("rd_after_wr_dirty", last_cw[535], 1'b1);

    // reset while ALLOCATE is waiting on memory
    clear_set(IX);
    mem_hold = 1'b1;
    @(posedge clk); #1;
    cur_idx = IX; cpu_req_addr = A; cpu_req_rw = 1'b0; cpu_req_enable = 1'b1;
    @(posedge clk); #1;
    cpu_req_enable = 1'b0;
    seen = 0;
    for (int k = 0; k < 50 && seen == 0; k++) begin
      @(negedge clk);
      if (mem_req_enable && !mem_req_rw) seen = 1;
    end
    check("alloc_reached", seen, 1);
    rst_n = 1'b1;
    @(negedge clk);
    check_quiet("mid_reset");
    rst_n = 1'b0; mem_hold = 1'b0;
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (cpu_res_ready || mem_req_enable || cache_enable) seen++;
    end
    check("aborted_silent", seen, 0);

    // randomized traffic against the flat memory reference
    for (int s = 0; s < 128; s++) clear_set(7'(s));
    exp_words.delete();
    for (int t = 0; t < 300; t++) begin
      ra = {21'(32'h100 + $urandom_range(0, 7)), ($urandom_range(0, 1) != 0) ? 7'h2C : 7'h05,
            4'($urandom_range(0, 15))};
      rrw = 1'($urandom_range(0, 1));
      rdat = $urandom;
      present = 1'b0;
      for (int w = 0; w < 4; w++)
        if (store[ra[10:4]][w][536] && store[ra[10:4]][w][532:512] == ra[31:11]) present = 1'b1;
      f0 = n_fetch;
      do_req(ra, rrw, rdat, rd);
      check("rnd_fetch", n_fetch - f0, present ? 0 : 1);
      if (rrw) exp_words[ra] = rdat;
      else check("rnd_rdata", rd, exp_read(ra));
      hit_after = 1'b0;
      for (int w = 0; w < 4; w++)
        if (store[ra[10:4]][w][536] && store[ra[10:4]][w][532:512] == ra[31:11]
            && store[ra[10:4]][w][534:533] == 2'd0) hit_after = 1'b1;
      check("rnd_resident", hit_after, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
